// File: rtl/mul_col_acc_64bit.sv
`default_nettype none
// ============================================================================
// Module   : mul_col_acc_64bit
// Brief    : Column accumulator behind a pipelined 64x64 multiplier; emits
//            one 64-bit word per column plus a two-word carry flush per block.
// Revision : 1.0 - initial release
// ============================================================================
module mul_col_acc_64bit #(
    parameter int MUL_LAT = 6,
    parameter int ACC_W   = 136
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tag_valid_i,
    input  logic          tag_col_last_i,
    input  logic          tag_blk_last_i,
    input  logic [127:0]  prod_i,
    output logic [63:0]   word_o,
    output logic          word_valid_o,
    output logic          done_o,
    output logic          busy_o,
    output logic          err_o
);

    localparam int c_PAD_W = ACC_W - 128;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_FLUSH0 = 2'd1,
        ST_FLUSH1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [MUL_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [MUL_LAT-1:0]   col_pipe_q, col_pipe_d;
    logic [MUL_LAT-1:0]   blk_pipe_q, blk_pipe_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [63:0]          word_q, word_d;
    logic                 word_valid_q, word_valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 dly_vld;
    logic                 dly_col;
    logic                 dly_blk;
    logic [ACC_W-1:0]     sum;

    // Tag delay line keeps each tag aligned with its product at prod_i.
    always_comb begin
        vld_pipe_d[0] = tag_valid_i;
        col_pipe_d[0] = tag_col_last_i;
        blk_pipe_d[0] = tag_blk_last_i;
        for (int i = 1; i < MUL_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            col_pipe_d[i] = col_pipe_q[i-1];
            blk_pipe_d[i] = blk_pipe_q[i-1];
        end
    end

    assign dly_vld = vld_pipe_q[MUL_LAT-1];
    assign dly_col = col_pipe_q[MUL_LAT-1];
    assign dly_blk = blk_pipe_q[MUL_LAT-1];
    assign sum     = acc_q + {{c_PAD_W{1'b0}}, prod_i};

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        done_d       = 1'b0;
        busy_d       = (state_q == ST_FLUSH0) || (state_q == ST_FLUSH1);
        err_d        = err_q;
        case (state_q)
            ST_ACC: begin
                if (dly_vld) begin
                    if (dly_col || dly_blk) begin
                        word_d       = sum[63:0];
                        word_valid_d = 1'b1;
                        acc_d        = sum >> 64;
                        if (dly_blk) begin
                            state_d = ST_FLUSH0;
                        end
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            ST_FLUSH0: begin
                // A product landing here is dropped; flush proceeds untouched.
                word_d       = acc_q[63:0];
                word_valid_d = 1'b1;
                acc_d        = acc_q >> 64;
                state_d      = ST_FLUSH1;
                if (dly_vld) begin
                    err_d = 1'b1;
                end
            end
            ST_FLUSH1: begin
                word_d       = acc_q[63:0];
                word_valid_d = 1'b1;
                done_d       = 1'b1;
                acc_d        = '0;
                state_d      = ST_ACC;
                if (dly_vld) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ACC;
            vld_pipe_q   <= '0;
            col_pipe_q   <= '0;
            blk_pipe_q   <= '0;
            acc_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_pipe_q   <= vld_pipe_d;
            col_pipe_q   <= col_pipe_d;
            blk_pipe_q   <= blk_pipe_d;
            acc_q        <= acc_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_col_acc_64bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_col_acc_64bit
// Brief    : Self-checking bench: directed vector table, cycle-exact and
//            corner-case sequences, and a small random block run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_col_acc_64bit;

    localparam int MUL_LAT = 6;
    localparam int ACC_W   = 136;
    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tag_valid_i, tag_col_last_i, tag_blk_last_i;
    logic [127:0]  prod_i;
    logic [63:0]   word_o;
    logic          word_valid_o, done_o, busy_o, err_o;
    logic [63:0]   op_a, op_b;

    always #5 clk = ~clk;

    mul_col_acc_64bit #(.MUL_LAT(MUL_LAT), .ACC_W(ACC_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tag_valid_i    (tag_valid_i),
        .tag_col_last_i (tag_col_last_i),
        .tag_blk_last_i (tag_blk_last_i),
        .prod_i         (prod_i),
        .word_o         (word_o),
        .word_valid_o   (word_valid_o),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    // Multiplier stand-in: product appears MUL_LAT cycles after its operands.
    logic [MUL_LAT-1:0] pv = '0;
    logic [127:0]       pp [MUL_LAT];
    always @(posedge clk) begin
        pv    <= {pv[MUL_LAT-2:0], tag_valid_i};
        pp[0] <= {64'b0, op_a} * {64'b0, op_b};
        for (int i = MUL_LAT - 1; i > 0; i--) pp[i] <= pp[i-1];
    end
    assign prod_i = pv[MUL_LAT-1] ? pp[MUL_LAT-1] : 'x;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [63:0] w;
        logic        d;
    } ev_t;
    ev_t got_q[$];
    ev_t exp_q[$];

    always @(negedge clk) begin
        if (rst_n && word_valid_o) got_q.push_back({word_o, done_o});
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input bit v, input bit cl, input bit bl,
                         input logic [63:0] a, input logic [63:0] b);
        tag_valid_i    = v;
        tag_col_last_i = cl;
        tag_blk_last_i = bl;
        op_a           = a;
        op_b           = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic expect_word(input logic [63:0] w, input bit d);
        exp_q.push_back({w, d});
    endtask

    task automatic compare_queues(input string nm);
        int n;
        check({nm, " count"}, 128'(got_q.size()), 128'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s word%0d", nm, i), {64'b0, got_q[i].w}, {64'b0, exp_q[i].w});
            check($sformatf("%s done%0d", nm, i), {127'b0, got_q[i].d}, {127'b0, exp_q[i].d});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        string              name;
        int                 n;
        logic [3:0][63:0]   a;
        logic [3:0][63:0]   b;
        logic [3:0]         cl;
        logic [3:0]         bl;
        int                 ne;
        logic [4:0][63:0]   ew;
    } vec_t;
    vec_t vt[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [191:0] macc;
        logic [127:0] pr;
        logic [63:0]  ra, rb;
        int ncol, np;
        bit cl, bl;

        // Directed vectors with hand-computed words.
        vt[0].name = "single_ones"; vt[0].n = 1;
        vt[0].a[0] = c_ONES; vt[0].b[0] = c_ONES; vt[0].cl = 4'b0001; vt[0].bl = 4'b0001;
        vt[0].ne = 3; vt[0].ew[0] = 64'h1; vt[0].ew[1] = 64'hFFFF_FFFF_FFFF_FFFE; vt[0].ew[2] = 64'h0;

        vt[1].name = "three_ones"; vt[1].n = 3;
        for (int i = 0; i < 3; i++) begin vt[1].a[i] = c_ONES; vt[1].b[i] = c_ONES; end
        vt[1].cl = 4'b0100; vt[1].bl = 4'b0100;
        vt[1].ne = 3; vt[1].ew[0] = 64'h3; vt[1].ew[1] = 64'hFFFF_FFFF_FFFF_FFFA; vt[1].ew[2] = 64'h2;

        vt[2].name = "two_cols"; vt[2].n = 2;
        vt[2].a[0] = 64'h8000_0000_0000_0000; vt[2].b[0] = 64'd4;
        vt[2].a[1] = 64'd1; vt[2].b[1] = 64'd5;
        vt[2].cl = 4'b0011; vt[2].bl = 4'b0010;
        vt[2].ne = 4; vt[2].ew[0] = 64'h0; vt[2].ew[1] = 64'h7; vt[2].ew[2] = 64'h0; vt[2].ew[3] = 64'h0;

        vt[3].name = "ones_x2"; vt[3].n = 1;
        vt[3].a[0] = c_ONES; vt[3].b[0] = 64'd2; vt[3].cl = 4'b0001; vt[3].bl = 4'b0001;
        vt[3].ne = 3; vt[3].ew[0] = 64'hFFFF_FFFF_FFFF_FFFE; vt[3].ew[1] = 64'h1; vt[3].ew[2] = 64'h0;

        vt[4].name = "carry_flush"; vt[4].n = 3;
        vt[4].a[0] = 64'd1; vt[4].b[0] = 64'd1;
        vt[4].a[1] = 64'd1; vt[4].b[1] = 64'd1;
        vt[4].a[2] = 64'h8000_0000_0000_0000; vt[4].b[2] = 64'd2;
        vt[4].cl = 4'b0110; vt[4].bl = 4'b0100;
        vt[4].ne = 4; vt[4].ew[0] = 64'h2; vt[4].ew[1] = 64'h0; vt[4].ew[2] = 64'h1; vt[4].ew[3] = 64'h0;

        rst_n = 1'b0;
        tag_valid_i = 0; tag_col_last_i = 0; tag_blk_last_i = 0; op_a = 0; op_b = 0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset word_o", {64'b0, word_o}, 128'd0);
        check("reset flags", {124'b0, word_valid_o, done_o, busy_o, err_o}, 128'd0);
        @(posedge clk); #1;

        // Cycle-exact latency, busy and done placement.
        tag_valid_i = 1; tag_col_last_i = 1; tag_blk_last_i = 1; op_a = c_ONES; op_b = c_ONES;
        t = cyc;
        @(posedge clk); #1;
        tag_valid_i = 0; tag_col_last_i = 0; tag_blk_last_i = 0;
        for (int k = 1; k <= 10; k++) begin
            bit ev, eb, ed;
            @(negedge clk);
            ev = (k >= 7 && k <= 9);
            eb = (k == 8 || k == 9);
            ed = (k == 9);
            check($sformatf("timing t+%0d valid/busy/done", cyc - t),
                  {125'b0, word_valid_o, busy_o, done_o}, {125'b0, ev, eb, ed});
            if (k == 7) check("timing word t+7", {64'b0, word_o}, 128'h1);
            if (k == 8) check("timing word t+8", {64'b0, word_o}, {64'b0, 64'hFFFF_FFFF_FFFF_FFFE});
            if (k == 9) check("timing word t+9", {64'b0, word_o}, 128'h0);
        end
        @(posedge clk); #1;
        got_q.delete();

        // Table-driven blocks, issued back to back within each block.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].n; i++)
                drive(1'b1, vt[v].cl[i], vt[v].bl[i], vt[v].a[i], vt[v].b[i]);
            idle(10);
            for (int i = 0; i < vt[v].ne; i++) expect_word(vt[v].ew[i], i == vt[v].ne - 1);
            compare_queues(vt[v].name);
        end

        // Reset in the middle of a column discards the in-flight products.
        drive(1'b1, 1'b0, 1'b0, c_ONES, c_ONES);
        drive(1'b1, 1'b0, 1'b0, c_ONES, c_ONES);
        idle(1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        got_q.delete();
        drive(1'b1, 1'b1, 1'b1, 64'd3, 64'd5);
        idle(10);
        expect_word(64'hF, 1'b0); expect_word(64'h0, 1'b0); expect_word(64'h0, 1'b1);
        compare_queues("mid_reset");
        check("mid_reset err", {127'b0, err_o}, 128'd0);

        // Valid tag one slot after blk_last lands in FLUSH0.
        drive(1'b1, 1'b1, 1'b1, 64'd3, 64'd5);
        drive(1'b1, 1'b0, 1'b0, 64'd7, 64'd7);
        idle(10);
        expect_word(64'hF, 1'b0); expect_word(64'h0, 1'b0); expect_word(64'h0, 1'b1);
        compare_queues("violation words");
        check("violation err set", {127'b0, err_o}, 128'd1);
        drive(1'b1, 1'b1, 1'b1, 64'd1, 64'd2);
        idle(10);
        expect_word(64'h2, 1'b0); expect_word(64'h0, 1'b0); expect_word(64'h0, 1'b1);
        compare_queues("after_violation");
        check("violation err sticky", {127'b0, err_o}, 128'd1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("err cleared by reset", {127'b0, err_o}, 128'd0);
        @(posedge clk); #1;
        got_q.delete();

        // Random blocks against a multi-word reference model.
        macc = '0;
        for (int blk = 0; blk < 150; blk++) begin
            ncol = $urandom_range(1, 8);
            for (int c = 0; c < ncol; c++) begin
                np = $urandom_range(1, 16);
                for (int p = 0; p < np; p++) begin
                    ra = ($urandom_range(0, 7) == 0) ? c_ONES : {$urandom, $urandom};
                    rb = ($urandom_range(0, 7) == 0) ? c_ONES : {$urandom, $urandom};
                    cl = (p == np - 1);
                    bl = cl && (c == ncol - 1);
                    pr = {64'b0, ra} * {64'b0, rb};
                    macc = macc + {64'b0, pr};
                    if (cl) begin
                        expect_word(macc[63:0], 1'b0);
                        macc = macc >> 64;
                    end
                    if (bl) begin
                        expect_word(macc[63:0], 1'b0);
                        macc = macc >> 64;
                        expect_word(macc[63:0], 1'b1);
                        macc = '0;
                    end
                    drive(1'b1, cl, bl, ra, rb);
                end
            end
            idle(2);
        end
        idle(12);
        compare_queues("random");
        check("random err", {127'b0, err_o}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
